// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if -- receive-byte handshake between uart_rx and its consumer.
//
// Signals:
//   rx_data_o  [7:0]  received byte (driven by the receiver)
//   rx_valid_o        byte available (driven by the receiver)
//   rx_ready_i        consumer accepts the byte when high with rx_valid_o
//
// Modports:
//   master  -- the receiver (uart_rx)
//   slave   -- the host-side consumer
// -----------------------------------------------------------------------------
interface uart_rx_if;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;

  modport master (
    output rx_data_o,
    output rx_valid_o,
    input  rx_ready_i
  );

  modport slave (
    input  rx_data_o,
    input  rx_valid_o,
    output rx_ready_i
  );
endinterface

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 16x oversampling UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN).
//
// Frames are 1 start bit, 8 data bits LSB-first, optional even parity bit and
// 1 stop bit. The oversample tick comes from a uart_baud instance in the sclk
// domain: every level change of baud_clk_i is one tick, 16 ticks per bit.
//
// Ports:
//   sclk          system clock, rising edge
//   rstn          asynchronous active-low reset
//   baud_clk_i    oversample clock from uart_baud (each toggle = one tick)
//   rxd_i         serial line, asynchronous, idle high
//   rx_if         byte handshake (master side): rx_data_o, rx_valid_o, rx_ready_i
//   busy_o        high whenever the receiver is not idle
//   frame_err_o   1-cycle pulse: stop bit sampled low, byte discarded
//   overrun_o     1-cycle pulse: byte completed while rx_valid_o still high
//   parity_err_o  1-cycle pulse: even parity mismatch (UART_RX_PARITY_EN only)
//
// Configuration macro: UART_RX_PARITY_EN -- adds the parity bit, the PARITY
// state and the parity_err_o port. Undefined gives plain 8N1.
// -----------------------------------------------------------------------------
module uart_rx (
  input  logic      sclk,
  input  logic      rstn,
  input  logic      baud_clk_i,
  input  logic      rxd_i,
  uart_rx_if.master rx_if,
  output logic      busy_o,
  output logic      frame_err_o,
  output logic      overrun_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic      parity_err_o
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t      state_q, state_d;
  logic        rxd_m, rxd_s;
  logic        baud_q;
  logic        tick, sample_pt, bit_end;
  logic [3:0]  os_cnt_q, os_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        deliver, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic        par_err_q, par_err_d, parity_err_d;
`endif

  assign tick      = baud_clk_i ^ baud_q;
  assign sample_pt = tick && (os_cnt_q == 4'd7);
  assign bit_end   = tick && (os_cnt_q == 4'd15);
  assign busy_o    = (state_q != ST_IDLE);

  // Line synchronizer resets to the idle (high) level so reset never looks
  // like a start bit.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      rxd_m  <= 1'b1;
      rxd_s  <= 1'b1;
      baud_q <= 1'b0;
    end else begin
      rxd_m  <= rxd_i;
      rxd_s  <= rxd_m;
      baud_q <= baud_clk_i;
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d    = par_err_q;
    parity_err_d = 1'b0;
`endif

    // Ticks only advance the bit timer while a frame is in progress.
    if (tick && state_q != ST_IDLE && state_q != ST_BREAK)
      os_cnt_d = os_cnt_q + 4'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (!rxd_s) begin
          state_d  = ST_START;
          os_cnt_d = 4'd0;
`ifdef UART_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (sample_pt && rxd_s) begin
          state_d = ST_IDLE;               // glitch, not a real start bit
        end else if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (sample_pt) shift_d[idx_q] = rxd_s;
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (sample_pt) par_err_d = ^{shift_q, rxd_s};
        if (bit_end)   state_d   = ST_STOP;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_STOP: begin
        // Decide at mid-stop and return to IDLE at once, leaving half a bit
        // of margin to catch the next start edge.
        if (sample_pt) begin
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_err_q;
`endif
          if (rxd_s) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      os_cnt_q         <= 4'd0;
      idx_q            <= 3'd0;
      shift_q          <= 8'h00;
      rx_if.rx_data_o  <= 8'h00;
      rx_if.rx_valid_o <= 1'b0;
      frame_err_o      <= 1'b0;
      overrun_o        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q        <= 1'b0;
      parity_err_o     <= 1'b0;
`endif
    end else begin
      os_cnt_q    <= os_cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_o <= frame_err_d;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= par_err_d;
      parity_err_o <= parity_err_d;
`endif
      // A byte being consumed this very cycle frees the slot for the new one.
      if (deliver) begin
        if (!rx_if.rx_valid_o || rx_if.rx_ready_i) begin
          rx_if.rx_data_o  <= shift_q;
          rx_if.rx_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (rx_if.rx_valid_o && rx_if.rx_ready_i) begin
        rx_if.rx_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx. Serial frames are built from
// an explicit tick stream (4 sclk per tick, 16 ticks per bit); bytes that must
// be delivered are queued when sent and compared when the consumer accepts
// them. Error pulses are counted cycle by cycle so pulse width is checked too.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  logic sclk = 1'b0;
  logic rstn = 1'b0;
  logic baud_clk_i = 1'b0;
  logic rxd_i = 1'b1;
  logic busy_o, frame_err_o, overrun_o;
`ifdef UART_RX_PARITY_EN
  logic parity_err_o;
`endif

  uart_rx_if rx_if ();

  uart_rx dut (
    .sclk        (sclk),
    .rstn        (rstn),
    .baud_clk_i  (baud_clk_i),
    .rxd_i       (rxd_i),
    .rx_if       (rx_if.master),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err_o(parity_err_o)
`endif
  );

  always #5 sclk = ~sclk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];
  int frame_err_cnt = 0;
  int overrun_cnt = 0;
  int parity_err_cnt = 0;

  // Scoreboard: every accepted byte must match the oldest queued one.
  always @(negedge sclk) begin
    if (frame_err_o) frame_err_cnt++;
    if (overrun_o) overrun_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err_o) parity_err_cnt++;
`endif
    if (rstn && rx_if.rx_valid_o && rx_if.rx_ready_i) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL accept_unexpected: got byte %02h, none expected", rx_if.rx_data_o);
      end else begin
        logic [7:0] exp_b;
        exp_b = exp_q.pop_front();
        if (rx_if.rx_data_o !== exp_b) begin
          tests_failed++;
          $display("FAIL accept_data: got %02h, expected %02h", rx_if.rx_data_o, exp_b);
        end
      end
    end
  end

  task automatic tick();
    repeat (4) @(posedge sclk);
    #1 baud_clk_i = ~baud_clk_i;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Start, data and (when enabled) parity bits; the caller drives the stop bit.
  task automatic send_head(input logic [7:0] d, input logic par);
    rxd_i = 1'b0;
    ticks(16);
    for (int i = 0; i < 8; i++) begin
      rxd_i = d[i];
      ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    rxd_i = par;
    ticks(16);
`endif
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_head(d, ^d);
    rxd_i = 1'b1;
    ticks(16);
  endtask

  // One-cycle ready pulse; the scoreboard compares the accepted byte.
  task automatic consume(input string name);
    @(posedge sclk);
    #1;
    tests_run++;
    if (rx_if.rx_valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_valid: rx_valid_o=%b, expected 1 before accept", name, rx_if.rx_valid_o);
    end else begin
      rx_if.rx_ready_i = 1'b1;
      @(posedge sclk);
      #1 rx_if.rx_ready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({rx_if.rx_valid_o, rx_if.rx_data_o, busy_o, frame_err_o, overrun_o} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b data=%02h busy=%b ferr=%b ovr=%b, expected all 0",
               rx_if.rx_valid_o, rx_if.rx_data_o, busy_o, frame_err_o, overrun_o);
    end
    repeat (3) @(posedge sclk);
    #1 rstn = 1'b1;
    ticks(4);
  endtask

  task automatic test_basic();
    exp_q.push_back(8'h55);
    send_head(8'h55, ^8'h55);
    rxd_i = 1'b1;
    ticks(7);
    tests_run++;
    if (rx_if.rx_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_early_valid: rx_valid_o=%b before stop sample, expected 0", rx_if.rx_valid_o);
    end
    tick();
    @(posedge sclk);
    #1;
    tests_run++;
    if (rx_if.rx_valid_o !== 1'b1 || rx_if.rx_data_o !== 8'h55) begin
      tests_failed++;
      $display("FAIL basic_delivery: valid=%b data=%02h, expected 1/55", rx_if.rx_valid_o, rx_if.rx_data_o);
    end
    ticks(8);
    repeat (20) @(posedge sclk);
    #1;
    tests_run++;
    if (rx_if.rx_valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_hold: rx_valid_o=%b without ready, expected 1", rx_if.rx_valid_o);
    end
    consume("basic");
    tests_run++;
    if (rx_if.rx_valid_o !== 1'b0 || rx_if.rx_data_o !== 8'h55) begin
      tests_failed++;
      $display("FAIL basic_clear: valid=%b data=%02h, expected 0/55", rx_if.rx_valid_o, rx_if.rx_data_o);
    end
  endtask

  task automatic test_false_start();
    int fe0, ov0;
    fe0 = frame_err_cnt;
    ov0 = overrun_cnt;
    rxd_i = 1'b0;
    ticks(4);
    rxd_i = 1'b1;
    ticks(3);
    tests_run++;
    if (busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL false_start_busy_hi: busy_o=%b at tick 7, expected 1", busy_o);
    end
    tick();
    @(posedge sclk);
    #1;
    tests_run++;
    if (busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL false_start_busy_lo: busy_o=%b after tick 8, expected 0", busy_o);
    end
    ticks(40);
    tests_run++;
    if (rx_if.rx_valid_o !== 1'b0 || frame_err_cnt != fe0 || overrun_cnt != ov0) begin
      tests_failed++;
      $display("FAIL false_start_quiet: valid=%b ferr_pulses=%0d ovr_pulses=%0d, expected 0/0/0",
               rx_if.rx_valid_o, frame_err_cnt - fe0, overrun_cnt - ov0);
    end
  endtask

  task automatic test_frame_error();
    int fe0;
    fe0 = frame_err_cnt;
    send_head(8'hA3, ^8'hA3);
    rxd_i = 1'b0;
    ticks(48);
    tests_run++;
    if (frame_err_cnt - fe0 != 1 || rx_if.rx_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_err_pulse: pulse_cycles=%0d valid=%b, expected 1/0",
               frame_err_cnt - fe0, rx_if.rx_valid_o);
    end
    tests_run++;
    if (busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL frame_err_busy: busy_o=%b during break, expected 1", busy_o);
    end
    rxd_i = 1'b1;
    repeat (5) @(posedge sclk);
    #1;
    tests_run++;
    if (busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_err_release: busy_o=%b after line high, expected 0", busy_o);
    end
    ticks(8);
  endtask

  task automatic test_back_to_back();
    int ov0;
    ov0 = overrun_cnt;
    exp_q.push_back(8'h12);
    send_frame(8'h12);
    send_frame(8'h34);
    tests_run++;
    if (overrun_cnt - ov0 != 1) begin
      tests_failed++;
      $display("FAIL overrun_pulse: pulse_cycles=%0d, expected 1", overrun_cnt - ov0);
    end
    tests_run++;
    if (rx_if.rx_valid_o !== 1'b1 || rx_if.rx_data_o !== 8'h12) begin
      tests_failed++;
      $display("FAIL overrun_keep: valid=%b data=%02h, expected 1/12", rx_if.rx_valid_o, rx_if.rx_data_o);
    end
    consume("overrun");
  endtask

  task automatic test_mid_reset();
    rxd_i = 1'b0;
    ticks(16);
    for (int i = 0; i < 3; i++) begin
      rxd_i = (i < 2);             // 0xC3 bits 0..2 = 1,1,0
      ticks(16);
    end
    rxd_i = 1'b0;                  // bit 3
    ticks(5);
    rstn = 1'b0;
    #1;
    tests_run++;
    if ({rx_if.rx_valid_o, rx_if.rx_data_o, busy_o, frame_err_o, overrun_o} !== 12'h000) begin
      tests_failed++;
      $display("FAIL mid_reset: valid=%b data=%02h busy=%b ferr=%b ovr=%b, expected all 0",
               rx_if.rx_valid_o, rx_if.rx_data_o, busy_o, frame_err_o, overrun_o);
    end
    rxd_i = 1'b1;
    repeat (3) @(posedge sclk);
    #1 rstn = 1'b1;
    ticks(8);
    tests_run++;
    if (busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_idle: busy_o=%b after release, expected 0", busy_o);
    end
    exp_q.push_back(8'hC3);
    send_frame(8'hC3);
    consume("after_reset");
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int pe0;
    pe0 = parity_err_cnt;
    exp_q.push_back(8'h07);
    send_head(8'h07, 1'b0);
    rxd_i = 1'b1;
    ticks(16);
    tests_run++;
    if (parity_err_cnt - pe0 != 1 || rx_if.rx_data_o !== 8'h07) begin
      tests_failed++;
      $display("FAIL parity_bad: pulse_cycles=%0d data=%02h, expected 1/07",
               parity_err_cnt - pe0, rx_if.rx_data_o);
    end
    consume("parity_bad");
    pe0 = parity_err_cnt;
    exp_q.push_back(8'h07);
    send_head(8'h07, 1'b1);
    rxd_i = 1'b1;
    ticks(16);
    tests_run++;
    if (parity_err_cnt != pe0) begin
      tests_failed++;
      $display("FAIL parity_good: pulse_cycles=%0d, expected 0", parity_err_cnt - pe0);
    end
    consume("parity_good");
  endtask
`endif

  initial begin
    rx_if.rx_ready_i = 1'b0;
    test_reset();
    test_basic();
    test_false_start();
    test_frame_error();
    test_back_to_back();
    test_mid_reset();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    repeat (4) @(posedge sclk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d bytes never accepted, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
